// File: rtl/axis_traffic_generator.sv
// rtl/axis_traffic_generator.sv - AXI4-Stream Ethernet frame source with sequence-numbered payloads
module axis_traffic_generator #(
    parameter int          AXIS_DATA_WIDTH  = 256,
    parameter int          AXIS_TUSER_WIDTH = 128,
    parameter logic [47:0] DST_MAC_ADDR     = 48'h1111_1111_1111,
    parameter logic [47:0] SRC_MAC_ADDR     = 48'h2222_2222_2222,
    parameter int          VLAN             = 1,
    parameter logic [15:0] ETH_TYPE         = 16'h0800,
    parameter int          SRC_PORT         = 0,
    parameter int          MIN_LEN          = 64,
    parameter int          MAX_LEN          = 1522
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          cfg_len_mode,
    input  logic [10:0]                   cfg_pkt_len,
    input  logic [15:0]                   cfg_gap,
    input  logic [15:0]                   cfg_pkt_count,
    input  logic [2:0]                    cfg_pcp,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   pkt_sent_cnt,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);
    localparam int          B        = AXIS_DATA_WIDTH / 8;
    localparam int          H        = (VLAN != 0) ? 18 : 14;
    localparam logic [7:0]  SRC_BYTE = (SRC_PORT <= 3) ? 8'(1 << (2 * SRC_PORT)) : 8'hAA;
    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t state;

    logic        mode_r, stop_pend;
    logic [15:0] gap_r, count_r, gap_cnt;
    logic [2:0]  pcp_r;
    logic [10:0] cur_len, beat;
    logic [31:0] seq;

    logic [10:0] clamp_len, next_len, nb_len, nb_idx;
    logic [31:0] nb_seq;
    logic [2:0]  nb_pcp;
    logic [AXIS_DATA_WIDTH-1:0]  nb_data;
    logic [B-1:0]                nb_keep;
    logic                        nb_last;
    logic [AXIS_TUSER_WIDTH-1:0] nb_user;
    logic hs, end_run;

    assign hs      = m_axis_tvalid & m_axis_tready;
    assign end_run = ((count_r != 16'd0) && (pkt_sent_cnt + 16'd1 == count_r)) | stop_pend | stop;

    always_comb begin
        clamp_len = cfg_pkt_len;
        if (cfg_pkt_len < MIN_L)      clamp_len = MIN_L;
        else if (cfg_pkt_len > MAX_L) clamp_len = MAX_L;
        next_len = cur_len;
        if (mode_r) next_len = (cur_len >= MAX_L) ? MIN_L : cur_len + 11'd1;
    end

    // Select which frame/beat the output register loads next; everything is computed one beat ahead.
    always_comb begin
        nb_len = cur_len;
        nb_idx = beat + 11'd1;
        nb_seq = seq;
        nb_pcp = pcp_r;
        case (state)
            IDLE: begin
                nb_len = clamp_len;
                nb_idx = 11'd0;
                nb_seq = 32'd0;
                nb_pcp = cfg_pcp;
            end
            SEND: if (m_axis_tlast) begin
                nb_len = next_len;
                nb_idx = 11'd0;
                nb_seq = seq + 32'd1;
            end
            default: nb_idx = 11'd0;
        endcase
    end

    always_comb begin
        int n;
        int rem;
        logic [7:0] bv;
        n       = 0;
        bv      = 8'd0;
        nb_data = '0;
        for (int k = 0; k < B; k++) begin
            n = int'(nb_idx) * B + k;
            if (n < 6)                  bv = 8'(DST_MAC_ADDR >> (8 * (5 - n)));
            else if (n < 12)            bv = 8'(SRC_MAC_ADDR >> (8 * (11 - n)));
            else if (VLAN != 0 && n < 16)
                bv = (n == 12) ? 8'h81 : (n == 14) ? {nb_pcp, 5'b0} : 8'h00;
            else if (n < H)             bv = (n == H - 2) ? ETH_TYPE[15:8] : ETH_TYPE[7:0];
            else if (n < H + 4)         bv = 8'(nb_seq >> (8 * (H + 3 - n)));
            else                        bv = 8'(n);
            nb_data[8*k +: 8] = bv;
        end
        nb_last = ((int'(nb_idx) + 1) * B) >= int'(nb_len);
        rem     = int'(nb_len) % B;
        nb_keep = '1;
        if (nb_last && rem != 0) nb_keep = {B{1'b1}} >> (B - rem);
        nb_user        = '0;
        nb_user[15:0]  = {5'b0, nb_len};
        nb_user[23:16] = SRC_BYTE;
    end

    always_ff @(posedge axis_aclk) begin
        done <= 1'b0;
        if (axis_reset) begin
            state <= IDLE;  busy <= 1'b0;  pkt_sent_cnt <= '0;  seq <= '0;
            m_axis_tvalid <= 1'b0;  m_axis_tlast <= 1'b0;
            m_axis_tdata <= '0;  m_axis_tkeep <= '0;  m_axis_tuser <= '0;
            mode_r <= 1'b0;  stop_pend <= 1'b0;  gap_r <= '0;  count_r <= '0;
            gap_cnt <= '0;  pcp_r <= '0;  cur_len <= '0;  beat <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_r <= cfg_len_mode;  gap_r <= cfg_gap;  count_r <= cfg_pkt_count;
                    pcp_r <= cfg_pcp;  cur_len <= clamp_len;  beat <= '0;
                    seq <= '0;  pkt_sent_cnt <= '0;  stop_pend <= 1'b0;  busy <= 1'b1;
                    m_axis_tdata <= nb_data;  m_axis_tkeep <= nb_keep;
                    m_axis_tlast <= nb_last;  m_axis_tuser <= nb_user;
                    m_axis_tvalid <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    if (stop) stop_pend <= 1'b1;
                    if (hs) begin
                        if (!m_axis_tlast || (!end_run && gap_r == 16'd0)) begin
                            beat <= nb_idx;
                            m_axis_tdata <= nb_data;  m_axis_tkeep <= nb_keep;
                            m_axis_tlast <= nb_last;  m_axis_tuser <= nb_user;
                        end
                        if (m_axis_tlast) begin
                            seq <= seq + 32'd1;
                            pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
                            cur_len <= next_len;
                            if (end_run) begin
                                m_axis_tvalid <= 1'b0;  m_axis_tlast <= 1'b0;
                                busy <= 1'b0;  done <= 1'b1;
                                state <= IDLE;
                            end else if (gap_r != 16'd0) begin
                                m_axis_tvalid <= 1'b0;
                                gap_cnt <= gap_r;
                                state <= GAP;
                            end
                        end
                    end
                end
                default: begin
                    if (stop || stop_pend) begin
                        busy <= 1'b0;  done <= 1'b1;
                        state <= IDLE;
                    end else if (gap_cnt == 16'd1) begin
                        beat <= '0;
                        m_axis_tdata <= nb_data;  m_axis_tkeep <= nb_keep;
                        m_axis_tlast <= nb_last;  m_axis_tuser <= nb_user;
                        m_axis_tvalid <= 1'b1;
                        state <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/axis_traffic_generator.md
Name: axis_traffic_generator

Overview:
Parametrised AXI4-Stream Ethernet frame source for TSN switch testbenches. Runtime-configurable length, inter-packet gap, packet count, VLAN PCP and a length-sweep mode. Each payload carries a sequence number for checker-side loss and reorder detection. Drives a switch input port's s_axis_* slave in place of a fixed-length free-running source, and fully honours tready backpressure.

Parameters:
AXIS_DATA_WIDTH, 256, tdata width; multiple of 64, range 64..512; B = AXIS_DATA_WIDTH/8 bytes per beat
AXIS_TUSER_WIDTH, 128, tuser width; at least 24
DST_MAC_ADDR, 48'h1111_1111_1111, destination MAC
SRC_MAC_ADDR, 48'h2222_2222_2222, source MAC
VLAN, 1, 1 = insert 802.1Q tag
ETH_TYPE, 16'h0800, EtherType
SRC_PORT, 0, source-port index for tuser
MIN_LEN, 64, minimum frame bytes; at least 22
MAX_LEN, 1522, maximum frame bytes; at most 2047

Ports:
axis_aclk  in  1  clock
axis_reset  in  1  synchronous, active-high reset
start  in  1  pulse; latches cfg_* and begins a run; ignored while busy
stop  in  1  pulse; ends the run at the next packet boundary
cfg_len_mode  in  1  0 = fixed length, 1 = sweep
cfg_pkt_len  in  11  frame length in bytes
cfg_gap  in  16  idle cycles between packets
cfg_pkt_count  in  16  packets per run; 0 = unlimited
cfg_pcp  in  3  VLAN priority
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pkt_sent_cnt  out  16  packets completed in current/last run
m_axis_tdata  out  AXIS_DATA_WIDTH  frame data
m_axis_tkeep  out  B  byte enables
m_axis_tuser  out  AXIS_TUSER_WIDTH  sideband
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  ready
m_axis_tlast  out  1  last beat

Behaviour:
- Reset: tvalid, tlast, busy and done are 0. tdata, tkeep, tuser, pkt_sent_cnt, the sequence counter and the FSM all clear; FSM goes to IDLE. Reset mid-packet drops tvalid at that edge; no tlast is emitted.
- Frame layout (byte n of frame): bytes 0-5 DST_MAC, 6-11 SRC_MAC.
  - VLAN=1: bytes 12-13 = 0x8100; byte 14 = {pcp, 5'b0}; byte 15 = 0x00; bytes 16-17 = ETH_TYPE; header length H = 18.
  - VLAN=0: bytes 12-13 = ETH_TYPE; H = 14.
  - Bytes H..H+3 = 32-bit sequence number, big-endian.
  - Bytes after that = n[7:0].
- Lane mapping: beat b, lane k (tdata[8k+:8]) carries byte b*B + k. Beats per frame = ceil(len/B).
- tkeep is all ones except on the last beat, where it is the low (len mod B) bits set, or all ones if len mod B = 0.
- tuser: [15:0] = frame length; [23:16] = SRC = 1 << (2*SRC_PORT) for SRC_PORT ≤ 3, else 8'hAA; upper bits 0. tuser is constant for all beats of a frame.
- Length: effective length = clamp(cfg_pkt_len, MIN_LEN, MAX_LEN).
  - Mode 0: every frame uses the same length.
  - Mode 1: first frame uses the clamped value; each following frame is +1; after MAX_LEN the next frame is MIN_LEN.
- FSM states:
  - IDLE: start=1 latches cfg_*, clears pkt_sent_cnt and the sequence number, sets busy, goes to SEND. The first beat is valid on the next cycle (latency 1).
  - SEND: tvalid=1. The beat advances only on tvalid & tready; tdata, tkeep, tlast and tuser are held stable while stalled. On the tlast handshake: seq+1, pkt_sent_cnt+1, then:
    - If count reached (cfg_pkt_count ≠ 0) or stop is pending → IDLE, done=1 for one cycle, busy=0.
    - Else if gap = 0 → next frame's first beat on the next cycle (back-to-back, tvalid stays 1).
    - Else → GAP.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND.
- stop is captured into a sticky pending flag and never truncates a frame. stop in IDLE is ignored. stop in GAP → IDLE with done on the next cycle.
- start together with stop in IDLE: start wins, stop is discarded.
- pkt_sent_cnt and the sequence number wrap modulo 2^16 and 2^32 respectively.

Test Plan:
1. W=256, VLAN=1, len 64, count 3, gap 0, tready=1 → 6 contiguous beats; tlast on beats 2/4/6; last tkeep = 0xFFFFFFFF; bytes 18-21 = 0,1,2 per frame; done one cycle after the 6th beat; pkt_sent_cnt=3.
2. len 100, W=256, pcp=5 → 4 beats; last tkeep = 0x0000000F; tuser[15:0]=100; tuser[23:16]=0x01; byte 14 = 0xA0.
3. Random tready (50%), len 1522, count 20 → scoreboard byte-exact against the layout model; outputs stable whenever tvalid & !tready; no gaps in the sequence.
4. Mode 1, MIN 64, MAX 66, cfg_pkt_len 65, count 5 → lengths 65,66,64,65,66. cfg_pkt_len 10 in mode 0 → 64-byte frames.
5. gap 10 → tvalid low exactly 10 cycles between each tlast handshake and the next first beat.
6. count 0, stop mid-frame → frame completes, done pulses, no further tvalid. Reset mid-frame → tvalid 0 after that edge; restarted run begins at seq 0.
